imem_boot_loader: RTL

//  Upstream feeder of the single-cycle MIPS core. Receives a byte stream (valid/ready),

---
 rtl/mips_pkg.sv | 20 ++
 rtl/imem_boot_loader.sv | 122 ++++++++++++
 2 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core slice: boot-loader state encoding and stream framing constants.
package mips_pkg;

   localparam logic [2:0] LD_IDLE   = 3'd0;
   localparam logic [2:0] LD_LEN_HI = 3'd1;
   localparam logic [2:0] LD_LEN_LO = 3'd2;
   localparam logic [2:0] LD_LOAD   = 3'd3;
   localparam logic [2:0] LD_CHK    = 3'd4;
   localparam logic [2:0] LD_DONE   = 3'd5;
   localparam logic [2:0] LD_ERROR  = 3'd6;

   localparam int BOOT_LEN_BYTES = 2;
   localparam int BYTES_PER_WORD = 4;

   // States in which the loader consumes stream bytes.
   function automatic logic ld_accepts(input logic [2:0] st);
      return (st == LD_LEN_HI) || (st == LD_LEN_LO) || (st == LD_LOAD) || (st == LD_CHK);
   endfunction

endpackage

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: writes a big-endian program image into IM and holds the core in reset.
// Optional trailing XOR checksum check enabled by defining LOADER_CHECKSUM_EN.
module imem_boot_loader
   import mips_pkg::*;
#(
   parameter int IM_BYTES  = 1024,
   parameter int ADDR_W    = 10,
   parameter int MAX_WORDS = IM_BYTES / BYTES_PER_WORD
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [7:0]        im_wdata,
   output logic              cpu_rst,
   output logic              done,
   output logic              error
);

   localparam int CNT_W = ADDR_W + 1;

   logic [2:0]       state, state_nxt;
   logic [7:0]       len_hi;
   logic [15:0]      len_word;
   logic [CNT_W-1:0] cnt, cnt_inc, tot_bytes;
   logic             xfer, restart, last_byte;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]       xor_acc;
`endif

   assign xfer      = in_valid && in_ready;
   assign restart   = start && ((state == LD_IDLE) || (state == LD_DONE) || (state == LD_ERROR));
   assign len_word  = {len_hi, in_data};
   assign cnt_inc   = cnt + CNT_W'(1);
   assign last_byte = (cnt_inc == tot_bytes);

   // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         LD_IDLE, LD_DONE, LD_ERROR: if (start) state_nxt = LD_LEN_HI;
         LD_LEN_HI: if (xfer) state_nxt = LD_LEN_LO;
         LD_LEN_LO: begin
            if (xfer) begin
               if (len_word == 16'd0)
`ifdef LOADER_CHECKSUM_EN
                  state_nxt = LD_CHK;
`else
                  state_nxt = LD_DONE;
`endif
               else if (32'(len_word) > MAX_WORDS)
                  state_nxt = LD_ERROR;
               else
                  state_nxt = LD_LOAD;
            end
         end
         LD_LOAD: begin
            if (xfer && last_byte)
`ifdef LOADER_CHECKSUM_EN
               state_nxt = LD_CHK;
`else
               state_nxt = LD_DONE;
`endif
         end
`ifdef LOADER_CHECKSUM_EN
         LD_CHK: if (xfer) state_nxt = (in_data == xor_acc) ? LD_DONE : LD_ERROR;
`endif
         default: state_nxt = LD_IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they track the state register exactly.
   // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= LD_IDLE;
         in_ready  <= 1'b0;
         im_we     <= 1'b0;
         im_addr   <= '0;
         im_wdata  <= '0;
         cpu_rst   <= 1'b1;
         done      <= 1'b0;
         error     <= 1'b0;
         len_hi    <= '0;
         cnt       <= '0;
         tot_bytes <= '0;
`ifdef LOADER_CHECKSUM_EN
         xor_acc   <= '0;
`endif
      end else begin
         state    <= state_nxt;
         in_ready <= ld_accepts(state_nxt);
         cpu_rst  <= (state_nxt != LD_DONE);
         done     <= (state_nxt == LD_DONE);
         error    <= (state_nxt == LD_ERROR);
         im_we    <= 1'b0;

         if (restart) begin
            cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_acc <= '0;
`endif
         end
         if (state == LD_LEN_HI && xfer) len_hi <= in_data;
         if (state == LD_LEN_LO && xfer) tot_bytes <= CNT_W'(32'(len_word) * BYTES_PER_WORD);
         if (state == LD_LOAD && xfer) begin
            im_we    <= 1'b1;
            im_addr  <= cnt[ADDR_W-1:0];
            im_wdata <= in_data;
            cnt      <= cnt_inc;
`ifdef LOADER_CHECKSUM_EN
            xor_acc  <= xor_acc ^ in_data;
`endif
         end
      end
   end

endmodule
